instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the RV32I core. It sits directly upstream of the instruction decoder / `ControlUnit` and owns the program counter. It issues word reads to instruction memory through a valid/ready request channel and accepts in-order responses. Fetched words are held in a 2-entry prefetch buffer and presented to decode as `instrCode` with a matching `instrPc`. A redirect (branch/jump target) flushes everything in flight.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset. Bits [1:0] must be 0.
- `MAX_INFLIGHT`, default `2`: maximum combined count of buffered words plus outstanding requests. Legal values are 1–4.

Ports:
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `imemReqValid`, output, 1: a fetch request is presented this cycle.
- `imemReqAddr`, output, 32: word-aligned fetch address.
- `imemReqReady`, input, 1: memory accepts the request. Handshake completes when valid and ready are both high.
- `imemRspValid`, input, 1: a read response is present. Responses are in order, at least 1 cycle after the request is accepted.
- `imemRspData`, input, 32: the instruction word.
- `redirectValid`, input, 1: a PC redirect is requested this cycle.
- `redirectPc`, input, 32: the redirect target. Bits [1:0] are ignored and treated as 0.
- `instrValid`, output, 1: the buffer head is valid for decode.
- `instrReady`, input, 1: decode consumes the head. Pop occurs when valid and ready are both high.
- `instrCode`, output, 32: instruction word at the buffer head. Drives `ControlUnit.instrCode`.
- `instrPc`, output, 32: address of `instrCode`.

## Operation
- State:
  - `fetchPc`: next address to request.
  - `rspPc`: address of the next live response.
  - `liveCnt`: count of outstanding requests whose data will be kept.
  - `staleCnt`: count of outstanding requests whose data will be dropped.
  - FIFO: 2 entries, each holding {code, pc}, with a count of 0–2.
- Issue rule:
  - `imemReqValid = !reset && !redirectValid && (liveCnt + staleCnt + fifoCnt - pop) < MAX_INFLIGHT`.
  - `pop = instrValid && instrReady`.
  - `imemReqAddr = fetchPc`.
  - On handshake: `fetchPc += 4` (mod 2^32, wraps from 32'hFFFF_FFFC to 0), and `liveCnt++`.
- Response with `staleCnt > 0`: the data is dropped and `staleCnt--`. Stale responses always drain before live ones.
- Response with `staleCnt == 0`:
  - Push {imemRspData, rspPc} into the FIFO.
  - `rspPc += 4`, `liveCnt--`.
  - The credit rule guarantees the FIFO never overflows. A push and a pop in the same cycle with the FIFO full is legal.
- Response arriving while `liveCnt + staleCnt == 0` is a protocol error. It is ignored; counters are unchanged.
- Redirect cycle (`redirectValid = 1`) has priority over all other events:
  - FIFO flushed.
  - `fetchPc = rspPc = {redirectPc[31:2], 2'b00}`.
  - `staleCnt = liveCnt + staleCnt - (imemRspValid ? 1 : 0)`, and `liveCnt = 0`. A response arriving in the redirect cycle is discarded.
  - No request is issued and no pop occurs in that cycle: `instrValid` is masked to 0.
- Back-to-back redirects: the last one wins. Stale accounting accumulates correctly.
- `instrValid = (fifoCnt != 0) && !redirectValid`. `instrCode`/`instrPc` show the FIFO head and hold stable while `instrValid && !instrReady`.
- Reset mid-operation: all counters and the FIFO clear, and `fetchPc = rspPc = RESET_PC`. Responses to pre-reset requests are not allowed by the memory contract (memory is reset together with this block).

## Timing
- Reset values:
  - `imemReqValid = 0`, `imemReqAddr = RESET_PC`.
  - `instrValid = 0`, `instrCode = 32'h0000_0013` (NOP), `instrPc = RESET_PC`.
- First request: in the first cycle after `reset` deasserts.
- Latency from response to decode: 1 cycle. A word received in cycle N is visible with `instrValid = 1` in cycle N+1.
- Throughput, with 1-cycle memory, `imemReqReady = 1`, and `instrReady = 1`: 1 instruction per cycle after a 2-cycle warm-up.
- Redirect penalty with 1-cycle memory: target request issued in cycle R+1, target instruction valid in cycle R+3.
- `imemReqValid` and `imemReqAddr` are held stable while `imemReqReady = 0`, except when a redirect withdraws the request.
- Combinational paths:
  - `instrReady` → `imemReqValid`.
  - `redirectValid` → `imemReqValid`.
  - `redirectValid` → `instrValid`.
- No path exists from `imemRspValid` to any output in the same cycle.

## Test plan
- Reset release:
  - Stimulus: RESET_PC = 0x100; 1-cycle memory; ready high throughout.
  - Required: addresses 0x100, 0x104, 0x108… issued one per cycle. Decode sees `instrPc` 0x100 first, 2 cycles after reset. No gaps thereafter.
- Decode stall:
  - Stimulus: `instrReady = 0` for 5 cycles.
  - Required: `imemReqValid` drops once fifoCnt + liveCnt = 2. `instrCode`/`instrPc` hold. On release, PCs continue with no loss or duplication.
- Redirect with in-flight work:
  - Stimulus: 2 requests outstanding on 3-cycle memory; `redirectPc = 0x2002`.
  - Required: both old responses are dropped. The next request address is 0x2000. The first `instrPc` after redirect is 0x2000.
- Redirect coinciding with a response:
  - Stimulus: redirect and `imemRspValid` in the same cycle.
  - Required: that response is not pushed, and `staleCnt` excludes it. `instrValid = 0` in that cycle.
- Backpressure and wrap:
  - Stimulus: `imemReqReady` toggles randomly; redirect to 0xFFFF_FFF8.
  - Required: addr/valid stable while not ready. PCs go 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-stream:
  - Stimulus: assert `reset` with the FIFO full.
  - Required: outputs match the reset values next cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage with credit-limited imem requests,
// a 2-entry prefetch FIFO and redirect flush with stale-response accounting.
module instr_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instrCode,
    output logic [31:0] instrPc
);
    logic [31:0] r_fetch_pc;
    logic [31:0] r_rsp_pc;
    logic [2:0]  r_live;
    logic [2:0]  r_stale;
    logic [1:0]  r_cnt;
    logic        r_head;
    logic [31:0] r_code [2];
    logic [31:0] r_pc   [2];
    logic        w_pop;
    logic        w_hs;
    logic        w_rsp;
    logic        w_push;
    logic        w_drop;
    logic        w_tail;
    logic [3:0]  w_used;
    logic [31:0] w_tgt;

    assign w_tgt        = redirectPc & ~32'h3;
    assign instrValid   = (r_cnt != 2'd0) && !redirectValid;
    assign instrCode    = r_code[r_head];
    assign instrPc      = r_pc[r_head];
    assign w_pop        = instrValid && instrReady;
    // Credits freed by this cycle's pop may be reused immediately.
    assign w_used       = 4'(r_live) + 4'(r_stale) + 4'(r_cnt) - 4'(w_pop);
    assign imemReqValid = !reset && !redirectValid && (w_used < 4'(MAX_INFLIGHT));
    assign imemReqAddr  = r_fetch_pc;
    assign w_hs         = imemReqValid && imemReqReady;
    assign w_rsp        = imemRspValid && ((r_live != 3'd0) || (r_stale != 3'd0));
    assign w_drop       = w_rsp && (r_stale != 3'd0);
    assign w_push       = w_rsp && (r_stale == 3'd0);
    // When full, tail aliases head; a simultaneous pop frees that slot.
    assign w_tail       = r_head ^ r_cnt[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_live     <= 3'd0;
            r_stale    <= 3'd0;
            r_cnt      <= 2'd0;
            r_head     <= 1'b0;
            r_code[0]  <= 32'h0000_0013;
            r_code[1]  <= 32'h0000_0013;
            r_pc[0]    <= RESET_PC;
            r_pc[1]    <= RESET_PC;
        end else if (redirectValid) begin
            r_fetch_pc <= w_tgt;
            r_rsp_pc   <= w_tgt;
            r_stale    <= r_live + r_stale - 3'(w_rsp);
            r_live     <= 3'd0;
            r_cnt      <= 2'd0;
        end else begin
            if (w_hs)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push) begin
                r_code[w_tail] <= imemRspData;
                r_pc[w_tail]   <= r_rsp_pc;
                r_rsp_pc       <= r_rsp_pc + 32'd4;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_live  <= r_live + 3'(w_hs) - 3'(w_push);
            r_stale <= r_stale - 3'(w_drop);
            r_cnt   <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: bench with an in-order latency memory model, a queue of
// expected decode PCs, a table of redirect scenarios and hand-written corner cases.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] tgt;
        int          lat;
        int          req_mode;
        int          dec_mode;
        int          warm;
        int          ncyc;
        int          min_pops;
        int          max_pops;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady = 1'b1;
    logic        imemRspValid = 1'b0;
    logic [31:0] imemRspData = 32'h0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = 32'h0;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic [31:0] instrCode;
    logic [31:0] instrPc;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          since_rst = 0;
    int          pops = 0;
    int          lat = 1;
    int          req_mode = 0;
    int          dec_mode = 0;
    bit          chk_warm = 0;
    bit          last_req_valid;
    bit          prev_hold_req = 0;
    bit          prev_hold_dec = 0;
    logic [31:0] prev_addr;
    logic [31:0] prev_pc;
    logic [31:0] prev_code;
    logic [31:0] exp_req;
    logic [31:0] exp_q[$];
    mreq_t       mem_q[$];
    vec_t        tbl[5];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .MAX_INFLIGHT(2)) dut (
        .clk(clk), .reset(reset),
        .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .instrValid(instrValid), .instrReady(instrReady),
        .instrCode(instrCode), .instrPc(instrPc)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fill_exp(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 200; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirectValid = 1'b0;
        imemRspValid = 1'b0;
        imemReqReady = 1'b1;
        instrReady = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imemReqValid), 32'd0);
        check("rst_req_addr", imemReqAddr, RST_PC);
        check("rst_instr_valid", 32'(instrValid), 32'd0);
        check("rst_instr_code", instrCode, 32'h0000_0013);
        check("rst_instr_pc", instrPc, RST_PC);
        mem_q.delete();
        reset = 1'b0;
        exp_req = RST_PC;
        fill_exp(RST_PC);
        prev_hold_req = 0;
        prev_hold_dec = 0;
        since_rst = 0;
    endtask

    task automatic cycle(input bit redir, input logic [31:0] tgt);
        bit          hs;
        bit          pop;
        bit          rsp;
        logic [31:0] a;
        logic [31:0] e;
        redirectValid = redir;
        redirectPc = tgt;
        imemReqReady = (req_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        instrReady = (dec_mode == 1) ? 1'($urandom_range(0, 1)) : (dec_mode == 0);
        rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imemRspValid = rsp;
        imemRspData = rsp ? mdata(mem_q[0].addr) : 32'h0;
        #1;
        hs = imemReqValid && imemReqReady;
        pop = instrValid && instrReady;
        a = imemReqAddr;
        if (redir) begin
            check("redir_instr_valid", 32'(instrValid), 32'd0);
            check("redir_req_valid", 32'(imemReqValid), 32'd0);
        end
        if (prev_hold_req && !redir) begin
            check("req_hold_valid", 32'(imemReqValid), 32'd1);
            check("req_hold_addr", imemReqAddr, prev_addr);
        end
        if (prev_hold_dec && !redir) begin
            check("dec_hold_valid", 32'(instrValid), 32'd1);
            check("dec_hold_pc", instrPc, prev_pc);
            check("dec_hold_code", instrCode, prev_code);
        end
        if (chk_warm) begin
            check("warm_req_valid", 32'(imemReqValid), 32'd1);
            check("warm_instr_valid", 32'(instrValid), 32'(since_rst >= 2));
        end
        if (hs) begin
            check("req_addr", imemReqAddr, exp_req);
            exp_req += 32'd4;
        end
        if (pop) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got pc %h expected no instruction", instrPc);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", instrPc, e);
                check("instr_code", instrCode, mdata(e));
            end
        end
        prev_hold_req = imemReqValid && !imemReqReady;
        prev_addr = imemReqAddr;
        prev_hold_dec = instrValid && !instrReady;
        prev_pc = instrPc;
        prev_code = instrCode;
        last_req_valid = imemReqValid;
        @(posedge clk);
        if (rsp) void'(mem_q.pop_front());
        if (hs) mem_q.push_back('{a, cyc + lat});
        cyc++;
        since_rst++;
        if (redir) begin
            exp_req = tgt & ~32'h3;
            fill_exp(exp_req);
        end
        #1;
    endtask

    initial begin
        tbl[0] = '{32'h0000_2002, 3, 0, 0, 8, 30, 3, 30};
        tbl[1] = '{32'h0000_4000, 1, 0, 0, 6, 20, 18, 18};
        tbl[2] = '{32'hFFFF_FFF8, 2, 1, 1, 6, 60, 3, 60};
        tbl[3] = '{32'h0000_0800, 2, 1, 0, 5, 30, 3, 30};
        tbl[4] = '{32'h1234_5677, 1, 0, 1, 4, 30, 3, 30};

        do_reset();
        chk_warm = 1;
        repeat (10) cycle(1'b0, 32'h0);
        chk_warm = 0;

        dec_mode = 2;
        repeat (5) cycle(1'b0, 32'h0);
        check("stall_req_drop", 32'(last_req_valid), 32'd0);
        dec_mode = 0;
        repeat (10) cycle(1'b0, 32'h0);

        for (int i = 0; i < 5; i++) begin
            lat = tbl[i].lat;
            req_mode = tbl[i].req_mode;
            dec_mode = tbl[i].dec_mode;
            repeat (tbl[i].warm) cycle(1'b0, 32'h0);
            cycle(1'b1, tbl[i].tgt);
            pops = 0;
            repeat (tbl[i].ncyc) cycle(1'b0, 32'h0);
            checks++;
            if (pops < tbl[i].min_pops || pops > tbl[i].max_pops) begin
                errors++;
                $display("FAIL pops_after_redirect[%0d]: got %0d expected %0d..%0d",
                         i, pops, tbl[i].min_pops, tbl[i].max_pops);
            end
        end

        req_mode = 0;
        dec_mode = 2;
        lat = 1;
        repeat (6) cycle(1'b0, 32'h0);
        check("full_before_reset", 32'(instrValid), 32'd1);
        do_reset();
        dec_mode = 0;
        chk_warm = 1;
        repeat (8) cycle(1'b0, 32'h0);
        chk_warm = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
